// File: rtl/counter_ctrl.sv
// Command-driven controller for an up/down counter: loads a start value, then
// tracks the counter step by step against an internal expectation until the target.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_dir,
    output logic             load,
    output logic             updown,
    output logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
    localparam logic [WIDTH:0]   STEP_ONE = (WIDTH + 1)'(1);

    state_t           state_r;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] target_r;
    logic             dir_r;
    logic [WIDTH-1:0] exp_r;

    // Next value the counter should show, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] next_exp(input logic [WIDTH-1:0] v, input logic up);
        next_exp = up ? (v + VAL_ONE) : (v - VAL_ONE);
    endfunction

    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);

    // Command sequencing, counter drive and step tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            start_r  <= {WIDTH{1'b0}};
            target_r <= {WIDTH{1'b0}};
            dir_r    <= 1'b0;
            exp_r    <= {WIDTH{1'b0}};
            load     <= 1'b0;
            updown   <= 1'b0;
            data     <= {WIDTH{1'b0}};
            done     <= 1'b0;
            err      <= 1'b0;
            steps    <= {(WIDTH + 1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    load <= 1'b0;
                    done <= 1'b0;
                    if (cmd_valid) begin
                        start_r  <= cmd_start;
                        target_r <= cmd_target;
                        dir_r    <= cmd_dir;
                        err      <= 1'b0;
                        steps    <= {(WIDTH + 1){1'b0}};
                        // Drive the load one cycle early so it is registered in LOAD.
                        load     <= 1'b1;
                        data     <= cmd_start;
                        updown   <= cmd_dir;
                        state_r  <= LOAD;
                    end
                end
                LOAD: begin
                    load    <= 1'b0;
                    updown  <= dir_r;
                    exp_r   <= start_r;
                    state_r <= RUN;
                end
                RUN: begin
                    load   <= 1'b0;
                    updown <= dir_r;
                    if (data_out != exp_r) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (data_out == target_r) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        exp_r <= next_exp(exp_r, dir_r);
                        steps <= steps + STEP_ONE;
                    end
                end
                DONE: begin
                    load    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    load    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural up/down counter attached.
module tb_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start = 4'd0;
    logic [WIDTH-1:0] cmd_target = 4'd0;
    logic             cmd_dir = 1'b0;
    logic             load;
    logic             updown;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH:0]   steps;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] cnt;
    logic             stuck = 1'b0;
    logic [WIDTH-1:0] stuck_val = 4'd0;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
        .load(load), .updown(updown), .data(data), .data_out(data_out),
        .busy(busy), .done(done), .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    // Behavioural counter: load on load, else count up or down every cycle.
    always @(posedge clk) begin
        if (load) cnt <= data;
        else if (updown) cnt <= cnt + 4'd1;
        else cnt <= cnt - 4'd1;
    end

    assign data_out = stuck ? stuck_val : cnt;

    // Accept one command from IDLE and follow it to done; done expected at T+exp_done.
    task automatic run_cmd(input string name, input logic [3:0] s, input logic [3:0] t,
                           input logic d, input int exp_done, input logic [4:0] exp_steps,
                           input logic exp_err);
        int  cyc;
        int  load_hi;
        bit  got;
        cmd_start = s; cmd_target = t; cmd_dir = d; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_at_T got %0b expected 1", name, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({load, data, updown, busy, cmd_ready, err, steps} !== {1'b1, s, d, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL %s t1 got load=%0b data=%0h updown=%0b busy=%0b ready=%0b err=%0b steps=%0d expected load=1 data=%0h updown=%0b busy=1 ready=0 err=0 steps=0",
                     name, load, data, updown, busy, cmd_ready, err, steps, s, d);
        end
        cyc = 1; load_hi = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
            else if (load) load_hi++;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s done_timeout got no done expected done at T+%0d", name, exp_done);
        end else if (cyc != exp_done) begin
            errors++; $display("FAIL %s done_cycle got T+%0d expected T+%0d", name, cyc, exp_done);
        end
        checks++;
        if (load_hi != 0) begin
            errors++; $display("FAIL %s load_extra got %0d cycles expected 0", name, load_hi);
        end
        checks++;
        if ({steps, err} !== {exp_steps, exp_err}) begin
            errors++; $display("FAIL %s result got steps=%0d err=%0b expected steps=%0d err=%0b",
                               name, steps, err, exp_steps, exp_err);
        end
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, busy, done, steps, err} !== {1'b1, 1'b0, 1'b0, exp_steps, exp_err}) begin
            errors++;
            $display("FAIL %s after_done got ready=%0b busy=%0b done=%0b steps=%0d err=%0b expected ready=1 busy=0 done=0 steps=%0d err=%0b",
                     name, cmd_ready, busy, done, steps, err, exp_steps, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({load, updown, data, done, err, steps, busy, cmd_ready} !== 15'b000000000000001) begin
            errors++; $display("FAIL reset_values got %015b expected 000000000000001",
                               {load, updown, data, done, err, steps, busy, cmd_ready});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            errors++; $display("FAIL reset_release got %03b expected 100", {cmd_ready, busy, done});
        end
    endtask

    task automatic test_count_up();
        run_cmd("up_3_to_7", 4'd3, 4'd7, 1'b1, 7, 5'd4, 1'b0);
    endtask

    task automatic test_count_down_wrap();
        run_cmd("down_wrap_2_to_14", 4'd2, 4'd14, 1'b0, 7, 5'd4, 1'b0);
    endtask

    task automatic test_equal();
        run_cmd("equal_5", 4'd5, 4'd5, 1'b1, 3, 5'd0, 1'b0);
    endtask

    task automatic test_fault();
        stuck_val = 4'd3; stuck = 1'b1;
        run_cmd("fault_stuck3", 4'd3, 4'd9, 1'b1, 4, 5'd1, 1'b1);
        stuck = 1'b0;
        // Flags from the faulted run must clear on the next accept.
        run_cmd("after_fault", 4'd8, 4'd10, 1'b1, 5, 5'd2, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        done_seen = 0;
        cmd_start = 4'd0; cmd_target = 4'd10; cmd_dir = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({load, updown, data, done, err, steps, busy, cmd_ready} !== 15'b000000000000001) begin
            errors++; $display("FAIL midrun_reset got %015b expected 000000000000001",
                               {load, updown, data, done, err, steps, busy, cmd_ready});
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL midrun_no_done got %0d pulses expected 0", done_seen);
        end
        run_cmd("reset_recover", 4'd0, 4'd1, 1'b1, 4, 5'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int load_hi;
        int bad_dir;
        int early;
        load_hi = 0; bad_dir = 0; early = 0;
        cmd_start = 4'd1; cmd_target = 4'd4; cmd_dir = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        checks++;
        if ({load, data} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL b2b_load got load=%0b data=%0h expected load=1 data=1", load, data);
        end
        while (cyc < 6) begin
            cmd_start  = 4'(cyc * 3);
            cmd_target = 4'(cyc + 8);
            cmd_dir    = (cyc % 2 == 0);
            @(posedge clk); #1;
            cyc++;
            if (load) load_hi++;
            if (updown !== 1'b1) bad_dir++;
            if (done && cyc != 6) early++;
        end
        checks++;
        if ({load_hi, bad_dir, early} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL b2b_ignored got load_hi=%0d bad_dir=%0d early=%0d expected 0 0 0",
                               load_hi, bad_dir, early);
        end
        checks++;
        if ({done, steps, err, cmd_ready} !== {1'b1, 5'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL b2b_first_done got done=%0b steps=%0d err=%0b ready=%0b expected 1 3 0 0",
                               done, steps, err, cmd_ready);
        end
        cmd_start = 4'd6; cmd_target = 4'd6; cmd_dir = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, load} !== 2'b10) begin
            errors++; $display("FAIL b2b_ready_t7 got ready=%0b load=%0b expected ready=1 load=0", cmd_ready, load);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if ({load, data, updown} !== {1'b1, 4'd6, 1'b0}) begin
            errors++; $display("FAIL b2b_second_load got load=%0b data=%0h updown=%0b expected 1 6 0",
                               load, data, updown);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({done, steps, err} !== {1'b1, 5'd0, 1'b0}) begin
            errors++; $display("FAIL b2b_second_done got done=%0b steps=%0d err=%0b expected 1 0 0",
                               done, steps, err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down_wrap();
        test_equal();
        test_fault();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
